// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NUM_REQ writeback sources.
// Optional busy-register scoreboard enabled by defining REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*5-1:0]  req_num,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [4:0]            write_num,
  output logic [31:0]           write_data,
  output logic                  write_en,
  input  logic                  rsv_en,
  input  logic [4:0]            rsv_num,
  input  logic [4:0]            busy1_num,
  input  logic [4:0]            busy2_num,
  output logic                  busy1,
  output logic                  busy2
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] scan_sel;
  int               scan_idx;
  logic             gnt_found;
  logic [4:0]       sel_num;
  logic [31:0]      sel_data;

  logic [4:0]       write_num_q, write_num_d;
  logic [31:0]      write_data_q, write_data_d;
  logic             write_en_q, write_en_d;

  // Scan from the pointer upward, wrapping once; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    scan_sel  = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_sel = scan_idx[PTR_W-1:0];
      if (!gnt_found && req_valid[scan_sel]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_sel;
      end
    end
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_num  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_num  = sel_num  | req_num[i*5 +: 5];
        sel_data = sel_data | req_data[i*32 +: 32];
      end
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    write_num_d  = write_num_q;
    write_data_d = write_data_q;
    write_en_d   = 1'b0;
    if (gnt_found) begin
      ptr_d        = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      write_num_d  = sel_num;
      write_data_d = sel_data;
      write_en_d   = (sel_num != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      write_num_q  <= '0;
      write_data_q <= '0;
      write_en_q   <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      write_num_q  <= write_num_d;
      write_data_q <= write_data_d;
      write_en_q   <= write_en_d;
    end
  end

  assign write_num  = write_num_q;
  assign write_data = write_data_q;
  assign write_en   = write_en_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Set is applied after clear so a new producer reserved on the commit edge stays pending.
  always_comb begin
    busy_d = busy_q;
    if (write_en_q) busy_d[write_num_q] = 1'b0;
    if (rsv_en)     busy_d[rsv_num]     = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy1 = busy_q[busy1_num];
  assign busy2 = busy_q[busy2_num];
`else
  logic unused_sb;
  assign unused_sb = ^{rsv_en, rsv_num, busy1_num, busy2_num};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: reference arbiter predicts grants,
// queued expectations are compared against the registered write port one cycle later.
module tb_regfile_wb_arbiter;
  localparam int N = 3;
`ifdef REGFILE_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  typedef struct packed {
    logic        en;
    logic [4:0]  num;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*5-1:0]  req_num = '0;
  logic [N*32-1:0] req_data = '0;
  logic [4:0]    write_num;
  logic [31:0]   write_data;
  logic          write_en;
  logic          rsv_en = 1'b0;
  logic [4:0]    rsv_num = '0;
  logic [4:0]    busy1_num = '0;
  logic [4:0]    busy2_num = '0;
  logic          busy1, busy2;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_data(req_data),
    .write_num(write_num), .write_data(write_data), .write_en(write_en),
    .rsv_en(rsv_en), .rsv_num(rsv_num),
    .busy1_num(busy1_num), .busy2_num(busy2_num),
    .busy1(busy1), .busy2(busy2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Regfile model: writes whatever the port presents, so a bogus $0 write is visible.
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (rst_n && write_en) rf[write_num] <= write_data;

  exp_t         exp_q [$];
  int           m_ptr = 0;
  logic [N-1:0] acc_mask = '0;

  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] exp_rdy;
    int           gi;
    bit           found;
    if (!rst_n) begin
      exp_q.delete();
      m_ptr    = 0;
      acc_mask = '0;
      check_eq("rst_wen", write_en, 0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("wen", write_en, e.en);
        if (e.en) begin
          check_eq("wnum", write_num, e.num);
          check_eq("wdata", write_data, e.data);
        end
      end else begin
        check_eq("idle_wen", write_en, 0);
      end
      exp_rdy = '0;
      found   = 1'b0;
      gi      = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          found = 1'b1;
          gi    = (m_ptr + k) % N;
        end
      end
      if (found) exp_rdy[gi] = 1'b1;
      check_eq("ready", req_ready, exp_rdy);
      acc_mask = req_valid & req_ready;
      if (found) begin
        e.num  = req_num[gi*5 +: 5];
        e.data = req_data[gi*32 +: 32];
        e.en   = (e.num != 5'd0);
        exp_q.push_back(e);
        m_ptr = (gi + 1) % N;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] n, input logic [31:0] d);
    req_valid[i]       = v;
    req_num[i*5 +: 5]  = n;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    // Reset with all requesters pending, then strict rotation.
    set_req(0, 1'b1, 5'd5, 32'hAAAA0001);
    set_req(1, 1'b1, 5'd6, 32'hAAAA0002);
    set_req(2, 1'b1, 5'd7, 32'hAAAA0003);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (6) cyc();
    req_valid = '0;
    repeat (2) cyc();
    check_eq("rf5", rf[5], 32'hAAAA0001);
    check_eq("rf6", rf[6], 32'hAAAA0002);
    check_eq("rf7", rf[7], 32'hAAAA0003);

    // Lone requester 2, then the pointer should favour requester 0.
    set_req(2, 1'b1, 5'd9, 32'hDEADBEEF);
    cyc();
    req_valid = '0;
    set_req(0, 1'b1, 5'd5, 32'hAAAA0001);
    set_req(1, 1'b1, 5'd6, 32'hAAAA0002);
    set_req(2, 1'b1, 5'd7, 32'hAAAA0003);
    cyc();
    req_valid = '0;
    repeat (2) cyc();
    check_eq("rf9", rf[9], 32'hDEADBEEF);

    // $0 write completes the handshake without a regfile write.
    set_req(1, 1'b1, 5'd0, 32'hFFFFFFFF);
    cyc();
    req_valid = '0;
    repeat (2) cyc();
    check_eq("rf0", rf[0], 32'h0);

    // Reset right after accept discards the pending write.
    set_req(0, 1'b1, 5'd20, 32'h5555AAAA);
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = '0;
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    check_eq("rf20_discard", rf[20], 32'h0);

    // Scoreboard reserve / clear / same-edge set-wins.
    busy1_num = 5'd12;
    busy2_num = 5'd13;
    rsv_en    = 1'b1;
    rsv_num   = 5'd12;
    @(negedge clk);
    check_eq("busy1_pre", busy1, 0);
    cyc();
    rsv_en = 1'b0;
    @(negedge clk);
    check_eq("busy1_rsv", busy1, SB);
    check_eq("busy2_other", busy2, 0);
    set_req(0, 1'b1, 5'd12, 32'h12121212);
    cyc();
    req_valid = '0;
    @(negedge clk);
    check_eq("busy1_wen", busy1, SB);
    cyc();
    @(negedge clk);
    check_eq("busy1_clr", busy1, 0);
    rsv_en  = 1'b1;
    rsv_num = 5'd12;
    cyc();
    rsv_en = 1'b0;
    set_req(0, 1'b1, 5'd12, 32'h34343434);
    cyc();
    req_valid = '0;
    rsv_en    = 1'b1;
    rsv_num   = 5'd12;
    cyc();
    rsv_en = 1'b0;
    @(negedge clk);
    check_eq("busy1_setwins", busy1, SB);
    cyc();
    @(negedge clk);
    check_eq("busy1_hold", busy1, SB);
    check_eq("rf12", rf[12], 32'h34343434);
    busy2_num = 5'd0;
    rsv_en    = 1'b1;
    rsv_num   = 5'd0;
    cyc();
    rsv_en = 1'b0;
    @(negedge clk);
    check_eq("busy_r0", busy2, 0);

    // Random traffic obeying hold-until-ready.
    repeat (40) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc_mask[i])
          set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      end
    end
    cyc();
    req_valid = '0;
    repeat (3) cyc();
    check_eq("q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
